axi_line_master: RTL and testbench
==================================

Name: axi_line_master

Overview:
- Parametrised AXI4 burst master that moves whole cache lines between the L1 caches and the external AXI bus.
- It replaces the core's raw start/last/bresp wiring with full AR/R/AW/W/B handshakes.
- One engine serves instruction-cache fills, data-cache fills and data-cache write-backs, one transaction at a time.
- Sits between the control unit/caches and the system interconnect.

Parameters:
- LINE_WIDTH, 512, cache line width in bits; must be a multiple of AXI_DATA_WIDTH.
- AXI_DATA_WIDTH, 64, AXI data bus width in bits; power of two, 32 to 512.
- ADDR_WIDTH, 64, address width.
- Derived: BEATS = LINE_WIDTH/AXI_DATA_WIDTH; BEATS must be ≤ 256.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- i_start_read in 1: request a line fill.
- i_start_write in 1: request a line write-back.
- i_addr in ADDR_WIDTH: line address; low log2(LINE_WIDTH/8) bits are ignored.
- i_line_wdata in LINE_WIDTH: line to write back.
- o_line_rdata out LINE_WIDTH: filled line.
- o_read_done out 1: one-cycle pulse, fill complete.
- o_write_done out 1: one-cycle pulse, write-back complete.
- o_busy out 1: a transaction is in progress.
- o_error out 1: a non-OKAY response or a burst-length violation occurred in the last completed transaction.
- o_araddr out ADDR_WIDTH; o_arlen out 8; o_arsize out 3; o_arburst out 2; o_arvalid out 1; i_arready in 1.
- i_rdata in AXI_DATA_WIDTH; i_rresp in 2; i_rlast in 1; i_rvalid in 1; o_rready out 1.
- o_awaddr out ADDR_WIDTH; o_awlen out 8; o_awsize out 3; o_awburst out 2; o_awvalid out 1; i_awready in 1.
- o_wdata out AXI_DATA_WIDTH; o_wstrb out AXI_DATA_WIDTH/8; o_wlast out 1; o_wvalid out 1; i_wready in 1.
- i_bresp in 2; i_bvalid in 1; o_bready out 1.

Behaviour:
- Reset (sync, active-high): state IDLE.
  - All valid, ready, done, busy and error outputs are 0.
  - o_line_rdata is 0; beat counter is 0.
  - Reset wins over every other event, including mid-burst. The bus is assumed reset together with this block.
- Burst fields:
  - Address is line-aligned: low log2(LINE_WIDTH/8) bits forced to 0.
  - len = BEATS-1; size = log2(AXI_DATA_WIDTH/8); burst = INCR (2'b01).
  - o_wstrb is all ones.
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE:
  - i_start_write=1 → AW. Write has priority when both starts are high, so the eviction precedes the fill.
  - Otherwise i_start_read=1 → AR.
  - On acceptance: register the address and snapshot i_line_wdata; clear o_error.
  - o_busy goes to 1 on the cycle after acceptance.
  - Starts are ignored whenever the state is not IDLE.
- AR:
  - o_arvalid=1; o_araddr and fields stay stable until i_arready.
  - arvalid && arready → R.
- R:
  - o_rready=1.
  - Each rvalid beat k writes i_rdata into o_line_rdata[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]; beat 0 is the least-significant slice.
  - Any i_rresp ≠ 0 sets the error flag (sticky for the transaction).
  - i_rlast on beat BEATS-1 → DONE.
  - i_rlast before beat BEATS-1 → set error, → DONE.
  - Beat BEATS-1 without i_rlast → set error, → DONE.
- AW:
  - o_awvalid=1, fields stable; awvalid && awready → W.
- W:
  - o_wvalid=1; o_wdata = snapshot slice k; o_wlast=1 only on beat BEATS-1.
  - Slice and wlast stay stable until i_wready; the counter advances only on wvalid && wready.
  - After the last beat is accepted → B.
- B:
  - o_bready=1; on i_bvalid, error |= (i_bresp ≠ 0) → DONE.
- DONE (1 cycle):
  - Pulse o_read_done or o_write_done, whichever matches the transaction.
  - o_error is valid in this cycle and holds until the next start is accepted.
  - → IDLE; o_busy is 0 on the same cycle as the pulse.
- Latency with zero bus wait states:
  - Read: start → done = 1 (AR) + BEATS (R) + 1 (DONE) cycles.
  - Write: 1 (AW) + BEATS (W) + 1 (B) + 1 (DONE) cycles.
- o_line_rdata holds its value after a read until the next read's first beat. Write-backs never disturb it.
- Beat counter width is max(1, $clog2(BEATS)) bits and wraps to 0 at each burst end.
- BEATS=1 is legal: a single beat with last=1.

Decomposition:
- Package axi_line_pkg holds:
  - the state enum;
  - AXI_RESP_OKAY = 2'b00;
  - AXI_BURST_INCR = 2'b01;
  - a function that computes axsize from a data width.
- One natural sub-module, line_beat_counter:
  - inputs: increment enable, clear;
  - outputs: index and last-beat flag;
  - parametrised by BEATS;
  - shared by the R and W paths.

Test Plan:
- Read, defaults, ready always high, i_addr=0x1234:
  - araddr=0x1200, arlen=7, arsize=3, arburst=1.
  - Beats 0x0..0x7 fill o_line_rdata slices 0..7.
  - o_read_done pulses at cycle 10; o_error=0.
- Write with random wready stalls, i_line_wdata={8{64'hA5..}} varied per slice:
  - Eight W beats, wdata stable during stalls, wlast only on beat 7.
  - bresp=0 → o_write_done pulses, o_error=0.
- i_start_read=i_start_write=1 in IDLE:
  - AW is issued first; read is not started.
  - After o_write_done, a new read start produces AR.
- Error responses:
  - rresp=2'b10 on beat 3 → o_error=1 at o_read_done; data slices still captured.
  - Separately, early rlast on beat 5 → o_error=1 and done.
- Reset and start handling:
  - rst=1 mid-R at beat 4 → next cycle all valid/ready=0, o_busy=0, state IDLE.
  - A start asserted while busy is ignored.
- Parameter sweep AXI_DATA_WIDTH=512:
  - One beat, arlen=0, arsize=6, rlast checked on beat 0.

Source files
------------

// File: rtl/axi_line_pkg.sv
// axi_line_pkg: shared types and constants for the AXI4 line master.
//   state_e        - transaction FSM states
//   AXI_RESP_OKAY  - OKAY response encoding
//   AXI_BURST_INCR - INCR burst encoding
//   axi_size()     - AxSIZE encoding for a given data bus width in bits
package axi_line_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // AxSIZE is log2 of the number of bytes per beat.
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/line_beat_counter.sv
// line_beat_counter: beat index within a line burst, shared by R and W paths.
//   clk, rst  - clock, synchronous active-high reset
//   i_inc     - one beat transferred this cycle
//   i_clr     - abandon the burst (index back to 0)
//   o_idx     - current beat index
//   o_last    - current beat is the final beat of the line
module line_beat_counter #(
    parameter  int BEATS = 8,
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [CW-1:0] o_idx,
    output logic          o_last
);

    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

    logic [CW-1:0] r_idx;

    // Wraps to 0 after the last beat so each burst starts clean.
    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_idx <= '0;
        else if (i_inc)
            r_idx <= o_last ? '0 : r_idx + CW'(1);
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/axi_line_master.sv
// axi_line_master: moves one cache line per transaction over AXI4 INCR bursts.
//   clk, rst                    - clock, synchronous active-high reset
//   i_start_read/i_start_write  - request fill / write-back (write wins)
//   i_addr, i_line_wdata        - line address and write-back data
//   o_line_rdata                - filled line, held until next fill's first beat
//   o_read_done/o_write_done    - one-cycle completion pulses
//   o_busy, o_error             - transaction in flight / last transaction failed
//   AR/R/AW/W/B channel ports   - AXI4 master interface
module axi_line_master
    import axi_line_pkg::*;
#(
    parameter int LINE_WIDTH     = 512,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH     = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start_read,
    input  logic                        i_start_write,
    input  logic [ADDR_WIDTH-1:0]       i_addr,
    input  logic [LINE_WIDTH-1:0]       i_line_wdata,
    output logic [LINE_WIDTH-1:0]       o_line_rdata,
    output logic                        o_read_done,
    output logic                        o_write_done,
    output logic                        o_busy,
    output logic                        o_error,
    output logic [ADDR_WIDTH-1:0]       o_araddr,
    output logic [7:0]                  o_arlen,
    output logic [2:0]                  o_arsize,
    output logic [1:0]                  o_arburst,
    output logic                        o_arvalid,
    input  logic                        i_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]                  i_rresp,
    input  logic                        i_rlast,
    input  logic                        i_rvalid,
    output logic                        o_rready,
    output logic [ADDR_WIDTH-1:0]       o_awaddr,
    output logic [7:0]                  o_awlen,
    output logic [2:0]                  o_awsize,
    output logic [1:0]                  o_awburst,
    output logic                        o_awvalid,
    input  logic                        i_awready,
    output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
    output logic                        o_wlast,
    output logic                        o_wvalid,
    input  logic                        i_wready,
    input  logic [1:0]                  i_bresp,
    input  logic                        i_bvalid,
    output logic                        o_bready
);

    localparam int BEATS    = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));
    localparam logic [7:0] AXLEN  = 8'(BEATS - 1);
    localparam logic [2:0] AXSIZE = axi_size(AXI_DATA_WIDTH);

    state_e                  r_state, w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_WIDTH-1:0]   r_wline;
    logic [LINE_WIDTH-1:0]   r_line_rdata;
    logic                    r_error;
    logic                    r_is_read;

    logic [CW-1:0]           w_idx;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_rbeat;
    logic                    w_wbeat;

    assign w_accept = (r_state == ST_IDLE) && (i_start_read || i_start_write);
    assign w_rbeat  = (r_state == ST_R) && i_rvalid;
    assign w_wbeat  = (r_state == ST_W) && i_wready;

    // An early rlast ends the burst before the counter wraps on its own.
    line_beat_counter #(.BEATS(BEATS)) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_rbeat || w_wbeat),
        .i_clr  (w_rbeat && i_rlast && !w_last),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        o_arvalid    = 1'b0;
        o_rready     = 1'b0;
        o_awvalid    = 1'b0;
        o_wvalid     = 1'b0;
        o_wlast      = 1'b0;
        o_bready     = 1'b0;
        o_read_done  = 1'b0;
        o_write_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start_write)     w_next = ST_AW;
                else if (i_start_read) w_next = ST_AR;
            end
            ST_AR: begin
                o_arvalid = 1'b1;
                if (i_arready) w_next = ST_R;
            end
            ST_R: begin
                o_rready = 1'b1;
                // Either marker of burst end terminates; mismatch is flagged as error.
                if (i_rvalid && (i_rlast || w_last)) w_next = ST_DONE;
            end
            ST_AW: begin
                o_awvalid = 1'b1;
                if (i_awready) w_next = ST_W;
            end
            ST_W: begin
                o_wvalid = 1'b1;
                o_wlast  = w_last;
                if (i_wready && w_last) w_next = ST_B;
            end
            ST_B: begin
                o_bready = 1'b1;
                if (i_bvalid) w_next = ST_DONE;
            end
            ST_DONE: begin
                o_read_done  = r_is_read;
                o_write_done = !r_is_read;
                w_next       = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_wline      <= '0;
            r_line_rdata <= '0;
            r_error      <= 1'b0;
            r_is_read    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= i_addr & ALIGN_MASK;
                r_wline   <= i_line_wdata;
                r_error   <= 1'b0;
                r_is_read <= !i_start_write;
            end
            if (w_rbeat) begin
                r_line_rdata[w_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
                if ((i_rresp != AXI_RESP_OKAY) || (i_rlast != w_last))
                    r_error <= 1'b1;
            end
            if ((r_state == ST_B) && i_bvalid && (i_bresp != AXI_RESP_OKAY))
                r_error <= 1'b1;
        end
    end

    assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_error      = r_error;
    assign o_line_rdata = r_line_rdata;

    assign o_araddr  = r_addr;
    assign o_arlen   = AXLEN;
    assign o_arsize  = AXSIZE;
    assign o_arburst = AXI_BURST_INCR;
    assign o_awaddr  = r_addr;
    assign o_awlen   = AXLEN;
    assign o_awsize  = AXSIZE;
    assign o_awburst = AXI_BURST_INCR;
    assign o_wdata   = r_wline[w_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign o_wstrb   = '1;

endmodule

// File: tb/tb_axi_line_master.sv
module tb_axi_line_master;
    localparam int LW = 512, DW = 64, AW = 64, NB = LW / DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default-parameter DUT
    logic i_start_read, i_start_write;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_line_wdata, o_line_rdata;
    logic o_read_done, o_write_done, o_busy, o_error;
    logic [AW-1:0] o_araddr, o_awaddr;
    logic [7:0] o_arlen, o_awlen;
    logic [2:0] o_arsize, o_awsize;
    logic [1:0] o_arburst, o_awburst;
    logic o_arvalid, i_arready, o_awvalid, i_awready;
    logic [DW-1:0] i_rdata, o_wdata;
    logic [1:0] i_rresp, i_bresp;
    logic i_rlast, i_rvalid, o_rready;
    logic [DW/8-1:0] o_wstrb;
    logic o_wlast, o_wvalid, i_wready, i_bvalid, o_bready;

    // single-beat DUT (data width = line width)
    logic s_start_read, s_start_write;
    logic [AW-1:0] s_addr;
    logic [LW-1:0] s_line_wdata, s_line_rdata;
    logic s_read_done, s_write_done, s_busy, s_error;
    logic [AW-1:0] s_araddr, s_awaddr;
    logic [7:0] s_arlen, s_awlen;
    logic [2:0] s_arsize, s_awsize;
    logic [1:0] s_arburst, s_awburst;
    logic s_arvalid, s_arready, s_awvalid, s_awready;
    logic [LW-1:0] s_rdata, s_wdata;
    logic [1:0] s_rresp, s_bresp;
    logic s_rlast, s_rvalid, s_rready;
    logic [LW/8-1:0] s_wstrb;
    logic s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

    axi_line_master #(.LINE_WIDTH(LW), .AXI_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .i_start_read(i_start_read), .i_start_write(i_start_write),
        .i_addr(i_addr), .i_line_wdata(i_line_wdata), .o_line_rdata(o_line_rdata),
        .o_read_done(o_read_done), .o_write_done(o_write_done), .o_busy(o_busy), .o_error(o_error),
        .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
        .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
        .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
    );

    axi_line_master #(.LINE_WIDTH(LW), .AXI_DATA_WIDTH(LW), .ADDR_WIDTH(AW)) dut_w (
        .clk(clk), .rst(rst), .i_start_read(s_start_read), .i_start_write(s_start_write),
        .i_addr(s_addr), .i_line_wdata(s_line_wdata), .o_line_rdata(s_line_rdata),
        .o_read_done(s_read_done), .o_write_done(s_write_done), .o_busy(s_busy), .o_error(s_error),
        .o_araddr(s_araddr), .o_arlen(s_arlen), .o_arsize(s_arsize), .o_arburst(s_arburst),
        .o_arvalid(s_arvalid), .i_arready(s_arready),
        .i_rdata(s_rdata), .i_rresp(s_rresp), .i_rlast(s_rlast), .i_rvalid(s_rvalid), .o_rready(s_rready),
        .o_awaddr(s_awaddr), .o_awlen(s_awlen), .o_awsize(s_awsize), .o_awburst(s_awburst),
        .o_awvalid(s_awvalid), .i_awready(s_awready),
        .o_wdata(s_wdata), .o_wstrb(s_wstrb), .o_wlast(s_wlast), .o_wvalid(s_wvalid), .i_wready(s_wready),
        .i_bresp(s_bresp), .i_bvalid(s_bvalid), .o_bready(s_bready)
    );

    typedef struct { logic [LW-1:0] line; logic err; } rd_exp_t;
    typedef struct { logic [DW-1:0] data; logic last; } w_exp_t;
    rd_exp_t rd_q[$];
    w_exp_t  w_q[$];
    logic [LW-1:0] exp_line;   // model of the default DUT's o_line_rdata
    int n_assert = 0, n_fail = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet();
        check("q_arvalid", o_arvalid, 0);
        check("q_rready", o_rready, 0);
        check("q_awvalid", o_awvalid, 0);
        check("q_wvalid", o_wvalid, 0);
        check("q_bready", o_bready, 0);
        check("q_rd_done", o_read_done, 0);
        check("q_wr_done", o_write_done, 0);
        check("q_busy", o_busy, 0);
        check("q_error", o_error, 0);
        check("q_rdata", o_line_rdata, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] base,
                           input int errb, input int early, input bit poke);
        int cyc;
        rd_exp_t e;
        logic [LW-1:0] line;
        line = exp_line;
        i_addr = addr;
        i_start_read = 1;
        step();
        i_start_read = 0;
        cyc = 1;
        check("ar_valid", o_arvalid, 1);
        check("ar_addr", o_araddr, addr & ~64'h3f);
        check("ar_len", o_arlen, 7);
        check("ar_size", o_arsize, 3);
        check("ar_burst", o_arburst, 1);
        check("rd_busy", o_busy, 1);
        if (poke) i_start_write = 1;
        while (!o_rready && cyc < 20) begin step(); cyc++; end
        for (int k = 0; k < NB; k++) begin
            i_rvalid = 1;
            i_rdata  = base + DW'(k);
            i_rresp  = (k == errb) ? 2'b10 : 2'b00;
            i_rlast  = (k == NB - 1) || (k == early);
            line[k*DW +: DW] = i_rdata;
            step();
            cyc++;
            if (k == early) break;
        end
        i_rvalid = 0; i_rlast = 0; i_rresp = 0;
        e.line = line;
        e.err  = (errb >= 0) || (early >= 0);
        rd_q.push_back(e);
        while (!o_read_done && cyc < 40) begin step(); cyc++; end
        check("rd_done", o_read_done, 1);
        if (early < 0) check("rd_latency", cyc, NB + 2);
        check("rd_busy_at_done", o_busy, 0);
        e = rd_q.pop_front();
        check("rd_line", o_line_rdata, e.line);
        check("rd_err", o_error, e.err);
        exp_line = e.line;
        i_start_write = 0;
        step();
        check("idle_busy", o_busy, 0);
        check("idle_no_aw", o_awvalid, 0);
        check("err_hold", o_error, e.err);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                            input bit stall, input logic [1:0] bresp, input bit both);
        int cyc, stalls;
        w_exp_t w;
        for (int k = 0; k < NB; k++) begin
            w.data = line[k*DW +: DW];
            w.last = (k == NB - 1);
            w_q.push_back(w);
        end
        i_addr = addr;
        i_line_wdata = line;
        i_start_write = 1;
        i_start_read = both;
        step();
        i_start_write = 0;
        i_start_read = 0;
        i_line_wdata = ~line;          // the DUT must send its snapshot
        cyc = 1;
        check("aw_valid", o_awvalid, 1);
        check("aw_no_ar", o_arvalid, 0);
        check("aw_addr", o_awaddr, addr & ~64'h3f);
        check("aw_len", o_awlen, 7);
        check("aw_size", o_awsize, 3);
        check("aw_burst", o_awburst, 1);
        while (!o_wvalid && cyc < 20) begin step(); cyc++; end
        check("w_strb", o_wstrb, 8'hff);
        stalls = 0;
        while (w_q.size() > 0 && cyc < 200) begin
            w = w_q[0];
            check("w_valid", o_wvalid, 1);
            check("w_data", o_wdata, w.data);
            check("w_last", o_wlast, w.last);
            i_wready = !stall || stalls >= 3 || ($urandom_range(0, 2) != 0);
            if (i_wready) begin
                void'(w_q.pop_front());
                stalls = 0;
            end else stalls++;
            step();
            cyc++;
        end
        check("w_drained", w_q.size(), 0);
        w_q.delete();
        i_wready = 0;
        check("b_ready", o_bready, 1);
        i_bvalid = 1;
        i_bresp = bresp;
        step();
        cyc++;
        i_bvalid = 0;
        i_bresp = 0;
        while (!o_write_done && cyc < 250) begin step(); cyc++; end
        check("wr_done", o_write_done, 1);
        check("wr_rd_done_low", o_read_done, 0);
        check("wr_err", o_error, bresp != 2'b00);
        check("wr_busy_at_done", o_busy, 0);
        check("rdata_hold", o_line_rdata, exp_line);
        if (!stall) check("wr_latency", cyc, NB + 3);
        step();
        check("post_wr_no_ar", o_arvalid, 0);
        check("post_wr_busy", o_busy, 0);
    endtask

    initial begin
        logic [LW-1:0] wl, rnd;
        rd_exp_t e;
        rst = 1;
        i_start_read = 0; i_start_write = 0; i_addr = 0; i_line_wdata = 0;
        i_arready = 1; i_rdata = 0; i_rresp = 0; i_rlast = 0; i_rvalid = 0;
        i_awready = 1; i_wready = 0; i_bresp = 0; i_bvalid = 0;
        s_start_read = 0; s_start_write = 0; s_addr = 0; s_line_wdata = 0;
        s_arready = 1; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rvalid = 0;
        s_awready = 1; s_wready = 0; s_bresp = 0; s_bvalid = 0;
        exp_line = '0;
        repeat (3) step();
        check_quiet();
        rst = 0;
        step();

        // basic fill, beats 0..7
        do_read(64'h1234, 64'h0, -1, -1, 0);

        // write-back with random wready stalls
        for (int k = 0; k < NB; k++) wl[k*DW +: DW] = 64'hA5A5_A5A5_A5A5_A5A5 ^ DW'(k * 64'h0101_0000_0000_0011);
        do_write(64'h4010, wl, 1, 2'b00, 0);

        // both starts together: write first, then a fresh read; start_write poked while busy
        for (int k = 0; k < NB; k++) wl[k*DW +: DW] = {$urandom, $urandom};
        do_write(64'h8040, wl, 0, 2'b00, 1);
        do_read(64'h8040, 64'h1000, -1, -1, 1);

        // error responses
        do_read(64'h2000, 64'h2200, 3, -1, 0);
        do_read(64'h3000, 64'h3300, -1, 5, 0);
        do_write(64'h5000, wl, 0, 2'b10, 0);
        // error cleared by the next accepted transaction
        do_read(64'h6000, 64'h6600, -1, -1, 0);

        // reset mid-read at beat 4
        i_addr = 64'h100; i_start_read = 1; step(); i_start_read = 0; step();
        for (int k = 0; k < 4; k++) begin
            i_rvalid = 1; i_rdata = 64'hB0 + DW'(k); i_rlast = 0; step();
        end
        i_rdata = 64'hB4;
        rst = 1;
        step();
        check_quiet();
        rst = 0; i_rvalid = 0;
        exp_line = '0;
        step();
        check("post_rst_busy", o_busy, 0);
        do_read(64'h7000, 64'h7700, -1, -1, 0);

        // single-beat configuration
        s_addr = 64'h12345; s_start_read = 1; step(); s_start_read = 0;
        check("sw_arvalid", s_arvalid, 1);
        check("sw_arlen", s_arlen, 0);
        check("sw_arsize", s_arsize, 6);
        check("sw_araddr", s_araddr, 64'h12340);
        step();
        check("sw_rready", s_rready, 1);
        for (int k = 0; k < 16; k++) rnd[k*32 +: 32] = $urandom;
        s_rdata = rnd; s_rvalid = 1; s_rlast = 1;
        e.line = rnd; e.err = 0; rd_q.push_back(e);
        step();
        s_rvalid = 0; s_rlast = 0;
        check("sw_done", s_read_done, 1);
        e = rd_q.pop_front();
        check("sw_line", s_line_rdata, e.line);
        check("sw_err", s_error, e.err);
        step();
        s_start_read = 1; step(); s_start_read = 0; step();
        s_rdata = ~rnd; s_rvalid = 1; s_rlast = 0;
        e.line = ~rnd; e.err = 1; rd_q.push_back(e);
        step();
        s_rvalid = 0;
        check("sw_done_nolast", s_read_done, 1);
        e = rd_q.pop_front();
        check("sw_line_nolast", s_line_rdata, e.line);
        check("sw_err_nolast", s_error, e.err);
        step();
        check("sw_idle", s_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
